// File: rtl/msx_bus_initiator.sv
// -----------------------------------------------------------------------------
// msx_bus_initiator
//
// Host-side end of the MSX cartridge slot bus. Each accepted single-beat
// request becomes one Z80-style memory or I/O bus cycle:
//   IDLE -> SETUP (SETUP_CYCLES) -> STROBE (STROBE_CYCLES) [-> WAIT]
//        -> HOLD (HOLD_CYCLES) -> DONE -> IDLE
// The slot outputs are registered from the current state, so each bus phase
// appears on the pins one clock after the state enters it. With the default
// parameters, a request sampled at edge 0 gives ACK high after edge 8.
//
// Optional feature (compile-time macro MSX_INIT_TIMEOUT_EN):
//   defined     - WAIT is bounded by WAIT_TIMEOUT cycles. On expiry the strobes
//                 are released and the cycle completes with ERR=1 and, for
//                 reads, RSP_DATA=8'hFF. ERR is cleared by the next accepted
//                 request.
//   not defined - WAIT is unbounded and ERR is tied to 0.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req                 request valid (taken only in IDLE, i.e. BUSY=0)
//   i_req_write           1 = write, 0 = read
//   i_req_io              1 = I/O cycle (IORQ_n, ADDR[15:8]=0)
//                         0 = memory cycle (MREQ_n, SLTSL_n)
//   i_req_addr[15:0]      request address
//   i_req_data[7:0]       request write data
//   o_busy                request in progress
//   o_ack                 one-cycle completion pulse
//   o_rsp_data[7:0]       read data; valid with ACK, held until the next
//                         read completion
//   o_err                 timeout flag, valid with ACK
//   o_addr[15:0]          slot address bus
//   o_dout[7:0]           data to the cartridge
//   i_din[7:0]            data from the cartridge
//   o_sltsl_n, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n   slot strobes, active low
//   i_wait_n              cartridge wait request (asynchronous)
//   i_busdir_n            cartridge data-direction indication; observed only
// -----------------------------------------------------------------------------
module msx_bus_initiator #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int WAIT_TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_req_write,
    input  logic        i_req_io,
    input  logic [15:0] i_req_addr,
    input  logic [7:0]  i_req_data,
    output logic        o_busy,
    output logic        o_ack,
    output logic [7:0]  o_rsp_data,
    output logic        o_err,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dout,
    input  logic [7:0]  i_din,
    output logic        o_sltsl_n,
    output logic        o_mreq_n,
    output logic        o_iorq_n,
    output logic        o_rd_n,
    output logic        o_wr_n,
    input  logic        i_wait_n,
    input  logic        i_busdir_n
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_HW = (HOLD_CYCLES > WAIT_TIMEOUT) ? HOLD_CYCLES : WAIT_TIMEOUT;
    localparam int MAX_P  = (MAX_SS > MAX_HW) ? MAX_SS : MAX_HW;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
`ifdef MSX_INIT_TIMEOUT_EN
    localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_accept;
    logic            w_capture;

    // Two-flop synchroniser for the asynchronous WAIT_n input.
    logic            r_wait_meta;
    logic            r_wait_sync;

    // Latched request fields and captured read data.
    logic            r_write;
    logic            r_io;
    logic [15:0]     r_addr;
    logic [7:0]      r_dout;
    logic [7:0]      r_cap;

    // Registered outputs.
    logic            r_busy;
    logic            r_ack;
    logic [7:0]      r_rsp;
    logic            r_sltsl_n;
    logic            r_mreq_n;
    logic            r_iorq_n;
    logic            r_rd_n;
    logic            r_wr_n;

    logic            w_slot_active;
    logic            w_strobe_active;

`ifdef MSX_INIT_TIMEOUT_EN
    logic            w_timeout;
    logic            r_timed_out;
    logic            r_err;
`endif

    // BUSDIR_n is only informative: read capture never depends on it.
    logic            w_unused_busdir;
    assign w_unused_busdir = i_busdir_n;

    // SLTSL_n covers the whole cycle up to DONE; the strobes cover STROBE+WAIT.
    assign w_slot_active   = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                             (r_state == ST_WAIT)  || (r_state == ST_HOLD);
    assign w_strobe_active = (r_state == ST_STROBE) || (r_state == ST_WAIT);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
`ifdef MSX_INIT_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                    w_cnt_next   = '0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_next = ST_STROBE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_STROBE: begin
                // WAIT_n is only looked at on the last strobe cycle.
                if (r_cnt == STROBE_LAST) begin
                    w_cnt_next = '0;
                    if (!r_wait_sync) begin
                        w_state_next = ST_WAIT;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_wait_sync) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end
`ifdef MSX_INIT_TIMEOUT_EN
                else if (r_cnt == WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wait_meta <= 1'b1;
            r_wait_sync <= 1'b1;
            r_write     <= 1'b0;
            r_io        <= 1'b0;
            r_addr      <= 16'h0000;
            r_dout      <= 8'h00;
            r_cap       <= 8'hFF;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_rsp       <= 8'hFF;
            r_sltsl_n   <= 1'b1;
            r_mreq_n    <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
`ifdef MSX_INIT_TIMEOUT_EN
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_wait_meta <= i_wait_n;
            r_wait_sync <= r_wait_meta;

            // Address/data go onto the bus at accept time and stay there
            // until the next accepted request.
            if (w_accept) begin
                r_write <= i_req_write;
                r_io    <= i_req_io;
                r_addr  <= i_req_io ? {8'h00, i_req_addr[7:0]} : i_req_addr;
                if (i_req_write) begin
                    r_dout <= i_req_data;
                end
            end

            if (w_capture) begin
                r_cap <= i_din;
            end

            r_sltsl_n <= ~(w_slot_active & ~r_io);
            r_mreq_n  <= ~(w_strobe_active & ~r_io);
            r_iorq_n  <= ~(w_strobe_active & r_io);
            r_rd_n    <= ~(w_strobe_active & ~r_write);
            r_wr_n    <= ~(w_strobe_active & r_write);

            r_ack <= (r_state == ST_DONE);

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end

            // Writes leave the last read result untouched.
            if ((r_state == ST_DONE) && !r_write) begin
                r_rsp <= r_cap;
            end

`ifdef MSX_INIT_TIMEOUT_EN
            if (w_accept) begin
                r_timed_out <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (w_timeout) begin
                    r_timed_out <= 1'b1;
                    r_cap       <= 8'hFF;
                end
                if (r_state == ST_DONE) begin
                    r_err <= r_timed_out;
                end
            end
`endif
        end
    end

    assign o_busy     = r_busy;
    assign o_ack      = r_ack;
    assign o_rsp_data = r_rsp;
    assign o_addr     = r_addr;
    assign o_dout     = r_dout;
    assign o_sltsl_n  = r_sltsl_n;
    assign o_mreq_n   = r_mreq_n;
    assign o_iorq_n   = r_iorq_n;
    assign o_rd_n     = r_rd_n;
    assign o_wr_n     = r_wr_n;
`ifdef MSX_INIT_TIMEOUT_EN
    assign o_err      = r_err;
`else
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_msx_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_msx_bus_initiator
//
// Self-checking bench for msx_bus_initiator. Every driven request pushes its
// expected completion (address, data, read result, ERR, ACK cycle and strobe
// low-widths) onto a scoreboard queue; a monitor pops and compares on ACK.
// Build with +define+MSX_INIT_TIMEOUT_EN to add the WAIT-timeout sequence.
// -----------------------------------------------------------------------------
module tb_msx_bus_initiator;

`ifdef MSX_INIT_TIMEOUT_EN
    localparam int TB_WT = 16;
`else
    localparam int TB_WT = 1024;
`endif
    // Bus phase lengths for the default parameter set.
    localparam int NS = 2;
    localparam int NT = 4;
    localparam int NH = 1;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req = 1'b0;
    logic        i_req_write = 1'b0;
    logic        i_req_io = 1'b0;
    logic [15:0] i_req_addr = 16'h0000;
    logic [7:0]  i_req_data = 8'h00;
    logic        o_busy;
    logic        o_ack;
    logic [7:0]  o_rsp_data;
    logic        o_err;
    logic [15:0] o_addr;
    logic [7:0]  o_dout;
    logic [7:0]  i_din = 8'h00;
    logic        o_sltsl_n;
    logic        o_mreq_n;
    logic        o_iorq_n;
    logic        o_rd_n;
    logic        o_wr_n;
    logic        i_wait_n = 1'b1;
    logic        i_busdir_n = 1'b1;

    msx_bus_initiator #(
        .SETUP_CYCLES (NS),
        .STROBE_CYCLES(NT),
        .HOLD_CYCLES  (NH),
        .WAIT_TIMEOUT (TB_WT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_req_write(i_req_write),
        .i_req_io   (i_req_io),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
        .o_busy     (o_busy),
        .o_ack      (o_ack),
        .o_rsp_data (o_rsp_data),
        .o_err      (o_err),
        .o_addr     (o_addr),
        .o_dout     (o_dout),
        .i_din      (i_din),
        .o_sltsl_n  (o_sltsl_n),
        .o_mreq_n   (o_mreq_n),
        .o_iorq_n   (o_iorq_n),
        .o_rd_n     (o_rd_n),
        .o_wr_n     (o_wr_n),
        .i_wait_n   (i_wait_n),
        .i_busdir_n (i_busdir_n)
    );

    always #5 i_clk = ~i_clk;

    // Edge counter: at #1/#2 after a rising edge, cyc equals that edge's index.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [7:0]  rsp;
        logic        err;
        int          ack_cyc;
        int          sl;
        int          mq;
        int          iq;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];

    // Reference state of the bus outputs that persist across transactions.
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] last_rsp   = 8'hFF;

    // -------------------------------------------------------------------------
    // Monitor: counts strobe low cycles and checks each completion.
    // -------------------------------------------------------------------------
    int   c_sl = 0, c_mq = 0, c_iq = 0, c_rd = 0, c_wr = 0;
    int   n_txn = 0;
    logic prev_ack = 1'b0;

    always begin
        @(posedge i_clk);
        #1;
        if (i_reset) begin
            c_sl = 0; c_mq = 0; c_iq = 0; c_rd = 0; c_wr = 0;
        end else begin
            if (!o_sltsl_n) c_sl++;
            if (!o_mreq_n)  c_mq++;
            if (!o_iorq_n)  c_iq++;
            if (!o_rd_n)    c_rd++;
            if (!o_wr_n)    c_wr++;
            if (o_ack) begin
                chk("ack_single_pulse", {31'd0, prev_ack}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ACK at edge %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_txn++;
                    $display("txn %0d: ack@%0d addr=%h dout=%h rsp=%h err=%0b sl=%0d mq=%0d iq=%0d rd=%0d wr=%0d",
                             n_txn, cyc, o_addr, o_dout, o_rsp_data, o_err, c_sl, c_mq, c_iq, c_rd, c_wr);
                    chk("ack_edge",    cyc, e.ack_cyc);
                    chk("addr",        {16'd0, o_addr}, {16'd0, e.addr});
                    chk("dout",        {24'd0, o_dout}, {24'd0, e.dout});
                    chk("rsp_data",    {24'd0, o_rsp_data}, {24'd0, e.rsp});
                    chk("err",         {31'd0, o_err}, {31'd0, e.err});
                    chk("busy_at_ack", {31'd0, o_busy}, 32'd0);
                    chk("sltsl_low",   c_sl, e.sl);
                    chk("mreq_low",    c_mq, e.mq);
                    chk("iorq_low",    c_iq, e.iq);
                    chk("rd_low",      c_rd, e.rd);
                    chk("wr_low",      c_wr, e.wr);
                end
                c_sl = 0; c_mq = 0; c_iq = 0; c_rd = 0; c_wr = 0;
            end
        end
        prev_ack = o_ack;
    end

    // Build the expected completion of one request accepted at edge e0.
    function automatic exp_t make_exp(input logic wr, input logic io, input logic [15:0] a,
                                      input logic [7:0] rsp, input logic err,
                                      input int e0, input int extra);
        exp_t e;
        int   strobe_len;
        strobe_len = NT + extra;
        e.addr    = io ? {8'h00, a[7:0]} : a;
        e.dout    = last_wdata;
        e.rsp     = rsp;
        e.err     = err;
        e.ack_cyc = e0 + 1 + NS + NT + NH + extra;
        e.sl      = io ? 0 : NS + strobe_len + NH;
        e.mq      = io ? 0 : strobe_len;
        e.iq      = io ? strobe_len : 0;
        e.rd      = wr ? 0 : strobe_len;
        e.wr      = wr ? strobe_len : 0;
        return e;
    endfunction

    // One request; WAIT_n is driven low for after-edges [w_from, w_to)
    // counted from the accept edge. Waits (bounded) for its completion.
    task automatic run_txn(input logic wr, input logic io, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] din, input logic busdir,
                           input logic [7:0] rd_exp, input logic err, input int extra,
                           input int w_from, input int w_to);
        int e0;
        e0 = cyc + 1;
        i_req       = 1'b1;
        i_req_write = wr;
        i_req_io    = io;
        i_req_addr  = a;
        i_req_data  = d;
        i_din       = din;
        i_busdir_n  = busdir;
        if (wr) last_wdata = d;
        else    last_rsp   = rd_exp;
        sb.push_back(make_exp(wr, io, a, last_rsp, err, e0, extra));
        @(posedge i_clk);
        #2;
        i_req = 1'b0;
        chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
        for (int k = 0; k < 80 && sb.size() != 0; k++) begin
            i_wait_n = (k >= w_from && k < w_to) ? 1'b0 : 1'b1;
            @(posedge i_clk);
            #2;
        end
        i_wait_n = 1'b1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got no ACK within budget, expected ACK at edge %0d", sb[0].ack_cyc);
            sb.delete();
        end
    endtask

    typedef struct {
        logic        wr;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  din;
        logic        busdir;
        logic [15:0] exp_addr;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e0;

        vecs[0] = '{1'b0, 1'b0, 16'h4000, 8'h00, 8'h41, 1'b1, 16'h4000, 8'h41};
        vecs[1] = '{1'b1, 1'b1, 16'h00A0, 8'h07, 8'hEE, 1'b1, 16'h00A0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 16'h12A0, 8'h55, 8'hEE, 1'b1, 16'h00A0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 16'h0098, 8'h00, 8'h9C, 1'b1, 16'h0098, 8'h9C};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 8'hAA, 8'h11, 1'b1, 16'h8000, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, 16'hFFFF, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 16'h3FFE, 8'h00, 8'hC3, 1'b0, 16'h00FE, 8'hC3};

        // Reset state.
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_ack",   {31'd0, o_ack}, 32'd0);
        chk("rst_err",   {31'd0, o_err}, 32'd0);
        chk("rst_rsp",   {24'd0, o_rsp_data}, 32'hFF);
        chk("rst_addr",  {16'd0, o_addr}, 32'd0);
        chk("rst_dout",  {24'd0, o_dout}, 32'd0);
        chk("rst_strobes", {27'd0, o_sltsl_n, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, 32'h1F);
        i_reset = 1'b0;
        @(posedge i_clk);
        #2;

        // Table of single transactions, no wait states.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].io, vecs[i].addr, vecs[i].data, vecs[i].din,
                    vecs[i].busdir, vecs[i].exp_rdata, 1'b0, 0, 1000, 1000);
            chk("vec_addr", {16'd0, o_addr}, {16'd0, vecs[i].exp_addr});
        end

        // WAIT stretch: WAIT_n low for 6 cycles starting at strobe fall. The
        // two-flop synchroniser adds two cycles, so RD_n is low 10 cycles and
        // ACK lands at edge 14.
        run_txn(1'b0, 1'b0, 16'h6000, 8'h00, 8'h5D, 1'b1, 8'h5D, 1'b0, 6, 3, 9);

        // REQ held for 20 edges with a moving address: accepts only at edges
        // 0, 9 and 18 (ACKs at 8, 17, 26).
        e0 = cyc + 1;
        i_din       = 8'h3C;
        i_req_write = 1'b0;
        i_req_io    = 1'b0;
        last_rsp    = 8'h3C;
        sb.push_back(make_exp(1'b0, 1'b0, 16'h5000, 8'h3C, 1'b0, e0, 0));
        sb.push_back(make_exp(1'b0, 1'b0, 16'h5009, 8'h3C, 1'b0, e0 + 9, 0));
        sb.push_back(make_exp(1'b0, 1'b0, 16'h5012, 8'h3C, 1'b0, e0 + 18, 0));
        for (int i = 0; i < 20; i++) begin
            i_req      = 1'b1;
            i_req_addr = 16'(32'h5000 + i);
            @(posedge i_clk);
            #2;
            if (i == 4) chk("b2b_busy_mid", {31'd0, o_busy}, 32'd1);
        end
        i_req = 1'b0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            @(posedge i_clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_ack_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end

        // Reset during STROBE: strobes released next cycle, no ACK afterwards.
        e0 = cyc + 1;
        i_req       = 1'b1;
        i_req_write = 1'b0;
        i_req_io    = 1'b0;
        i_req_addr  = 16'h7000;
        i_din       = 8'h99;
        sb.push_back(make_exp(1'b0, 1'b0, 16'h7000, 8'h99, 1'b0, e0, 0));
        @(posedge i_clk);
        #2;
        i_req = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        chk("mid_rd_low_before_reset", {31'd0, o_rd_n}, 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk);
        #2;
        sb.delete();
        last_rsp   = 8'hFF;
        last_wdata = 8'h00;
        chk("mid_rst_strobes", {27'd0, o_sltsl_n, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, 32'h1F);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_ack",  {31'd0, o_ack}, 32'd0);
        chk("mid_rst_rsp",  {24'd0, o_rsp_data}, 32'hFF);
        i_reset = 1'b0;
        repeat (15) @(posedge i_clk);
        #2;
        chk("mid_rst_idle_busy", {31'd0, o_busy}, 32'd0);
        $display("txn reset-during-strobe: strobes=%b busy=%0b rsp=%h",
                 {o_sltsl_n, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, o_busy, o_rsp_data);

        // Recovery read after reset.
        run_txn(1'b0, 1'b0, 16'h4001, 8'h00, 8'h77, 1'b1, 8'h77, 1'b0, 0, 1000, 1000);

`ifdef MSX_INIT_TIMEOUT_EN
        // WAIT_n stuck low: timeout after TB_WT cycles in WAIT, ERR=1 and
        // RSP_DATA=FF; the next request clears ERR.
        run_txn(1'b0, 1'b0, 16'h4002, 8'h00, 8'h5A, 1'b1, 8'hFF, 1'b1, TB_WT, 3, 1000);
        chk("err_held_after_ack", {31'd0, o_err}, 32'd1);
        run_txn(1'b0, 1'b0, 16'h4003, 8'h00, 8'h66, 1'b1, 8'h66, 1'b0, 0, 1000, 1000);
`endif

        repeat (3) @(posedge i_clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
